// File: rtl/asp_irq_ctrl_pkg.sv
// Shared BSP package for the ASP interrupt controller.
// Holds IRQ line constants, CSR word offsets, MASK reset value and FSM states.
package asp_irq_ctrl_pkg;

    localparam int BSP_NUM_INTERRUPT_LINES = 4;

    localparam int IRQ_DMA_0  = 0;
    localparam int IRQ_KERNEL = 1;
    localparam int IRQ_DMA_1  = 2;

    localparam int AVMM_AW  = 3;
    localparam int AVMM_DW  = 64;
    localparam int AVMM_BEW = 8;

    localparam logic [AVMM_AW-1:0] CSR_STATUS = 3'd0;
    localparam logic [AVMM_AW-1:0] CSR_MASK   = 3'd1;
    localparam logic [AVMM_AW-1:0] CSR_CLEAR  = 3'd2;
    localparam logic [AVMM_AW-1:0] CSR_RAW    = 3'd3;
    localparam logic [AVMM_AW-1:0] CSR_ID     = 3'd4;

    // All lines masked out of reset.
    localparam logic [AVMM_DW-1:0] MASK_RST = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_CLR = 2'd2
    } irq_state_e;

endpackage

// File: rtl/asp_irq_ctrl_if.sv
// AVMM CSR bus between host (master) and interrupt controller (slave).
// Ports: address/read/write/writedata/byteenable -> readdata/readdatavalid/waitrequest.
interface asp_irq_ctrl_if;
    import asp_irq_ctrl_pkg::*;

    logic [AVMM_AW-1:0]  avmm_address;
    logic                avmm_read;
    logic                avmm_write;
    logic [AVMM_DW-1:0]  avmm_writedata;
    logic [AVMM_BEW-1:0] avmm_byteenable;
    logic [AVMM_DW-1:0]  avmm_readdata;
    logic                avmm_readdatavalid;
    logic                avmm_waitrequest;

    modport master (
        output avmm_address, avmm_read, avmm_write,
        output avmm_writedata, avmm_byteenable,
        input  avmm_readdata, avmm_readdatavalid, avmm_waitrequest
    );

    modport slave (
        input  avmm_address, avmm_read, avmm_write,
        input  avmm_writedata, avmm_byteenable,
        output avmm_readdata, avmm_readdatavalid, avmm_waitrequest
    );

endinterface

// File: rtl/asp_irq_sync.sv
// Two-flop synchronizer for one asynchronous interrupt source line.
// Ports: clk, reset_n (async active-low), d (async in), q (synchronized out).
module asp_irq_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt controller: sticky pending, mask, W1C clear, host req/ack FSM.
// Ports: clk, reset_n, irq_in[NUM_IRQ], avmm (CSR slave), irq_req out, irq_ack in.
module asp_irq_ctrl
    import asp_irq_ctrl_pkg::*;
#(
    parameter int              NUM_IRQ      = BSP_NUM_INTERRUPT_LINES,
    parameter int              NUM_IRQ_USED = 3,
    parameter logic [63:0]     ID_VALUE     = 64'h4153_5049_5251_0001
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    asp_irq_ctrl_if.slave      avmm,
    output logic               irq_req,
    input  logic               irq_ack
);

    logic [NUM_IRQ-1:0] raw;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] clr;
    logic [AVMM_DW-1:0] rdata;
    logic               wr_en;
    logic               active;
    irq_state_e         state;
    logic               unused_bits;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        if (i < NUM_IRQ_USED) begin : g_used
            asp_irq_sync u_sync (
                .clk     (clk),
                .reset_n (reset_n),
                .d       (irq_in[i]),
                .q       (raw[i])
            );
        end else begin : g_unused
            assign raw[i] = 1'b0;
        end
    end

    assign unused_bits = ^{irq_in, avmm.avmm_writedata,
                           avmm.avmm_byteenable};

    assign avmm.avmm_waitrequest = 1'b0;

    // A read in the same cycle drops the write.
    assign wr_en = avmm.avmm_write && !avmm.avmm_read
                   && avmm.avmm_byteenable[0];

    always_comb begin
        clr = '0;
        if (wr_en && avmm.avmm_address == CSR_CLEAR)
            clr = avmm.avmm_writedata[NUM_IRQ-1:0];
    end

    always_comb begin
        rdata = '0;
        case (avmm.avmm_address)
            CSR_STATUS: rdata[NUM_IRQ-1:0] = pending;
            CSR_MASK:   rdata[NUM_IRQ-1:0] = mask;
            CSR_RAW:    rdata[NUM_IRQ-1:0] = raw;
            CSR_ID:     rdata = ID_VALUE;
            default:    rdata = '0;
        endcase
    end

    assign active = |(pending & ~mask);

    // Set beats clear; unused lines never set since raw is tied low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            mask    <= MASK_RST[NUM_IRQ-1:0];
        end else begin
            pending <= (pending & ~clr) | raw;
            if (wr_en && avmm.avmm_address == CSR_MASK)
                mask <= avmm.avmm_writedata[NUM_IRQ-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avmm.avmm_readdata      <= '0;
            avmm.avmm_readdatavalid <= 1'b0;
        end else begin
            avmm.avmm_readdatavalid <= avmm.avmm_read;
            if (avmm.avmm_read)
                avmm.avmm_readdata <= rdata;
        end
    end

    // One request per service episode: WAIT_CLR holds off until active drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            irq_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (active) begin
                        state   <= REQ;
                        irq_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state   <= WAIT_CLR;
                        irq_req <= 1'b0;
                    end
                end
                WAIT_CLR: begin
                    if (!active)
                        state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/asp_irq_ctrl.md
ASP_IRQ_CTRL -- requirements
Module: asp_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of interrupt source lines (matches BSP_NUM_INTERRUPT_LINES).
REQ-002 SHALL have parameter NUM_IRQ_USED, default 3, lines implemented; lines at index NUM_IRQ_USED and above read 0 and never set pending.
REQ-003 SHALL have parameter ID_VALUE, default 64'h4153_5049_5251_0001, constant returned by the ID CSR.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 irq_in  in  NUM_IRQ  level-sensitive sources; bit0 DMA_0, bit1 kernel, bit2 DMA_1.
REQ-007 avmm_address  in  3  64-bit word index into the CSR window.
REQ-008 avmm_read / avmm_write  in  1 each  AVMM command strobes.
REQ-009 avmm_writedata  in  64 / avmm_byteenable  in  8  write payload and lane enables.
REQ-010 avmm_readdata  out  64 / avmm_readdatavalid  out  1  read response.
REQ-011 avmm_waitrequest  out  1  backpressure; constant 0.
REQ-012 irq_req  out  1 / irq_ack  in  1  host interrupt request and acknowledge.

Function
REQ-013 Each irq_in bit SHALL pass through a 2-flop synchronizer; raw = synchronized value.
REQ-014 pending[i] SHALL set on any cycle raw[i]=1 (sticky) and clear only on a CLEAR write with bit i = 1; set wins when both occur in the same cycle.
REQ-015 CSR map (word index): 0 STATUS RO = pending; 1 MASK RW, 1 = masked; 2 CLEAR WO, write-1-to-clear, reads 0; 3 RAW RO = raw; 4 ID RO = ID_VALUE; 5-7 read 0, writes ignored.
REQ-016 Writes SHALL take effect only when avmm_byteenable[0]=1, using writedata[NUM_IRQ-1:0]; upper bits ignored.
REQ-017 Read latency SHALL be exactly 1 cycle: readdatavalid pulses one cycle after the read strobe; readdata holds the last value between reads.
REQ-018 A read SHALL return the CSR value sampled in the strobe cycle, before any same-cycle write updates.
REQ-019 avmm_read and avmm_write asserted together: read serviced, write dropped.
REQ-020 active = |(pending & ~MASK).
REQ-021 FSM IDLE: irq_req=0; active=1 -> REQ next cycle; irq_ack ignored.
REQ-022 FSM REQ: irq_req=1; irq_ack=1 -> WAIT_CLR; irq_req holds until ack, even if active drops.
REQ-023 FSM WAIT_CLR: irq_req=0; active=0 -> IDLE; one interrupt per service episode, no re-request while active stays 1.
REQ-024 Unmasking a pending bit in IDLE SHALL raise irq_req on the second cycle after the MASK write strobe.
REQ-025 Source-to-irq_req latency from IDLE SHALL be 4 cycles (2 sync, 1 pending, 1 FSM).

Reset
REQ-026 reset_n low SHALL asynchronously force: synchronizers 0, pending 0, MASK all-ones, FSM IDLE, irq_req 0, readdatavalid 0, readdata 0.
REQ-027 Reset mid-REQ SHALL drop irq_req immediately; an in-flight read produces no readdatavalid.
REQ-028 After reset release, a source held high re-enters pending; no interrupt until MASK is cleared.

Structure
REQ-029 CSR word offsets, MASK reset value and FSM state enum (IDLE, REQ, WAIT_CLR) SHALL reside in the shared BSP package next to the IRQ bit constants.
REQ-030 The per-line 2-flop synchronizer SHALL be a sub-module asp_irq_sync, instantiated NUM_IRQ_USED times.

Verification
REQ-031 MASK=0, pulse irq_in[1] for 1 cycle -> irq_req=1 at cycle 4; STATUS reads 0x2.
REQ-032 Ack, CLEAR write 0x2 -> FSM WAIT_CLR then IDLE; STATUS 0x0; irq_req stays 0.
REQ-033 irq_in[0] held high, CLEAR 0x1 in the same cycle as set -> STATUS still 0x1.
REQ-034 MASK reset 0x7-equivalent, irq_in[2] pulsed -> no irq_req; write MASK=0 -> irq_req 2 cycles after the write strobe.
REQ-035 Read word 4 -> readdatavalid 1 cycle later, data ID_VALUE; read word 6 -> 0; simultaneous read+write to MASK -> old value returned, MASK unchanged.
REQ-036 reset_n low while irq_req=1 -> irq_req=0 same cycle; after release MASK reads all-ones, STATUS 0x0.
